// File: rtl/line_arbiter.sv
// line_arbiter: round-robin owner arbiter and sequencer for the 8:1
// one-bit priority mux driving a shared idle-high serial line.
//
// Ports:
//   Clk      - system clock, rising edge
//   Reset_n  - asynchronous active-low reset
//   req      - per-requester request, held high while the line is wanted
//   grant    - one-hot current owner, 0 when the line is unowned
//   select   - mux select, index of the current owner
//   inactive - forces the line high, 1 whenever grant is 0
//   timeout  - one-cycle pulse after a hold-limit release
module line_arbiter #(
    parameter int MAX_HOLD     = 256,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       inactive,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    logic [1:0]    state;
    logic [2:0]    last;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    gcnt;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;

    // Search from last+1 upward; k = 8 lands on last itself, so the
    // previous owner is only chosen when nobody else is asking.
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            grant    <= 8'h00;
            select   <= 3'd0;
            inactive <= 1'b1;
            timeout  <= 1'b0;
            last     <= 3'd7;
            hold_cnt <= '0;
            gcnt     <= 8'h00;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        grant    <= 8'h01 << win;
                        select   <= win;
                        last     <= win;
                        inactive <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    // A dropped request takes precedence over the
                    // hold limit, so a coincident drop never pulses.
                    if (!req[select]) begin
                        state    <= GUARD;
                        grant    <= 8'h00;
                        inactive <= 1'b1;
                        gcnt     <= GUARD_LAST;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= GUARD;
                        grant    <= 8'h00;
                        inactive <= 1'b1;
                        gcnt     <= GUARD_LAST;
                        timeout  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                GUARD: begin
                    if (gcnt == 8'h00) begin
                        if (|req) begin
                            state    <= GRANT;
                            grant    <= 8'h01 << win;
                            select   <= win;
                            last     <= win;
                            inactive <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gcnt <= gcnt - 8'h01;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= 8'h00;
                    inactive <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_arbiter.sv
// tb_line_arbiter: directed scenarios plus randomized requests for
// line_arbiter, checked every cycle against a cycle-level owner model.
module tb_line_arbiter;

    localparam int MH = 8;
    localparam int GC = 2;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] select;
    logic       inactive;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // model: owner -1 = nobody; held = cycles owned so far;
    // gap = guard cycles still to run; sel = last select driven
    int owner;
    int held;
    int gap;
    int last;
    int sel;
    bit exp_to;

    line_arbiter #(.MAX_HOLD(MH), .GUARD_CYCLES(GC)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .req(req),
        .grant(grant),
        .select(select),
        .inactive(inactive),
        .timeout(timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        owner  = -1;
        held   = 0;
        gap    = 0;
        last   = 7;
        sel    = 0;
        exp_to = 1'b0;
    endtask

    function automatic int pick(input logic [7:0] r);
        for (int k = 1; k <= 8; k++)
            if (r[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    task automatic give(input logic [7:0] r);
        int w;
        w = pick(r);
        owner = w;
        last  = w;
        sel   = w;
        held  = 1;
    endtask

    task automatic model_update(input logic [7:0] r);
        exp_to = 1'b0;
        if (owner >= 0) begin
            if (!r[owner]) begin
                owner = -1;
                gap   = GC;
            end else if (held == MH) begin
                owner  = -1;
                gap    = GC;
                exp_to = 1'b1;
            end else begin
                held++;
            end
        end else if (gap > 0) begin
            gap--;
            if (gap == 0 && r != 8'h00) give(r);
        end else if (r != 8'h00) begin
            give(r);
        end
    endtask

    task automatic compare();
        logic [7:0] eg;
        logic [2:0] es;
        eg = (owner >= 0) ? 8'(1 << owner) : 8'h00;
        es = 3'(sel);
        checks++;
        if (grant !== eg || select !== es ||
            inactive !== (owner < 0) || timeout !== exp_to) begin
            errors++;
            $display("FAIL model t=%0t got g=%h s=%0d i=%b to=%b want g=%h s=%0d i=%b to=%b",
                     $time, grant, select, inactive, timeout,
                     eg, es, (owner < 0), exp_to);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge Clk);
        model_update(r);
        @(negedge Clk);
        compare();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        compare();
    endtask

    logic [7:0] r;
    int         ntime;

    initial begin
        req = 8'h00;
        Reset_n = 1'b0;
        model_reset();
        #1;
        do_reset();
        chk("reset_grant", grant, 8'h00);
        chk("reset_inactive", inactive, 1);
        chk("reset_select", select, 0);

        // single requester
        step(8'h08);
        chk("single_grant", grant, 8'h08);
        chk("single_select", select, 3);
        chk("single_inactive", inactive, 0);
        repeat (3) step(8'h08);
        step(8'h00);
        chk("single_release", grant, 8'h00);
        chk("single_rel_inactive", inactive, 1);
        step(8'h00);
        chk("single_guard2", grant, 8'h00);
        repeat (2) step(8'h00);

        // asynchronous reset mid-grant
        step(8'h08);
        chk("pre_reset_grant", grant, 8'h08);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_grant", grant, 8'h00);
        chk("async_inactive", inactive, 1);
        chk("async_select", select, 0);
        req = 8'h00;
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        compare();
        step(8'h01);
        chk("post_reset_grant", grant, 8'h01);

        // timeout rotation from a fresh start
        do_reset();
        ntime = 0;
        for (int i = 1; i <= 40; i++) begin
            step(8'h81);
            if (timeout) ntime++;
            if (i == 1)  chk("rot_first", grant, 8'h01);
            if (i == 8)  chk("rot_last01", grant, 8'h01);
            if (i == 9)  chk("rot_timeout", timeout, 1);
            if (i == 9)  chk("rot_guard1", grant, 8'h00);
            if (i == 10) chk("rot_to_clear", timeout, 0);
            if (i == 11) chk("rot_second", grant, 8'h80);
            if (i == 18) chk("rot_last80", grant, 8'h80);
            if (i == 21) chk("rot_third", grant, 8'h01);
        end
        chk("rot_pulses", ntime, 4);
        step(8'h00);
        repeat (3) step(8'h00);

        // simultaneous drop at the hold limit
        do_reset();
        repeat (8) step(8'h20);
        chk("sim_held", grant, 8'h20);
        step(8'h00);
        chk("sim_no_timeout", timeout, 0);
        chk("sim_release", grant, 8'h00);
        step(8'h00);
        step(8'h00);
        chk("sim_guard_end", inactive, 1);

        // pointer wrap after owner 7
        step(8'h80);
        chk("wrap_own7", grant, 8'h80);
        step(8'h00);
        step(8'h03);
        step(8'h03);
        chk("wrap_grant0", grant, 8'h01);
        step(8'h02);
        step(8'h02);
        step(8'h02);
        chk("wrap_grant1", grant, 8'h02);

        // withdrawn request during guard
        step(8'h00);
        step(8'h04);
        step(8'h00);
        chk("withdrawn_idle", grant, 8'h00);
        step(8'h00);
        chk("withdrawn_stay", grant, 8'h00);

        // randomized traffic, fast then slow request changes
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, (i < 1500) ? 3 : 15) == 0)
                r = 8'($urandom) & 8'($urandom);
            step(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
